// File: rtl/clk_rst_pkg.sv
// Shared definitions for the clkCPU reset sequencing blocks: sequencer
// state encoding, counter width helper and default cycle constants.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } rstseq_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_STABLE_CYCLES   = 1024;
  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 65536;
  localparam int LOSS_CNT_W          = 8;

  // Width able to hold the larger of two cycle counts without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_cpu_reset_sequencer_if.sv
// Reset sequencer bundle: PLL lock and button inputs, system reset/ready
// outputs and the lock-loss statistic. slave = sequencer side.
interface clk_cpu_reset_sequencer_if;
  logic                               pll_locked;
  logic                               btn_reset;
  logic                               sys_reset;
  logic                               sys_ready;
  logic [clk_rst_pkg::LOSS_CNT_W-1:0] lock_loss_count;

  modport master (
    output pll_locked, btn_reset,
    input  sys_reset, sys_ready, lock_loss_count
  );

  modport slave (
    input  pll_locked, btn_reset,
    output sys_reset, sys_ready, lock_loss_count
  );
endinterface

// File: rtl/rst_button_debounce.sv
// Synchroniser plus debouncer for the raw reset button. The debounced
// level flips only after DEBOUNCE_CYCLES consecutive synchronised samples
// that disagree with it; any agreeing sample restarts the count.
module rst_button_debounce
  import clk_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES, 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DB_W-1:0]        db_cnt;
  logic                   btn_s;

  assign btn_s = sync[SYNC_STAGES-1];

  // Shift the asynchronous button into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], btn_raw};
  end

  // Count disagreeing samples and flip the level once enough have been seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      btn_db <= ~btn_db;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_cpu_reset_sequencer.sv
// clkCPU-domain reset sequencer: holds sys_reset until PLL lock has been
// stable for STABLE_CYCLES, then HOLD_CYCLES more, and re-enters reset on
// lock loss or a debounced button press. Optional saturating lock-loss
// counter enabled by defining RSTSEQ_LOCK_LOSS_COUNT_EN.
module clk_cpu_reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                       clock,
  input  logic                       reset,
  clk_cpu_reset_sequencer_if.slave   bus
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   locked_s;
  logic                   btn_db;
  rstseq_state_t          state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   sys_reset_q, sys_ready_q;

  assign locked_s      = lock_sync[SYNC_STAGES-1];
  assign bus.sys_reset = sys_reset_q;
  assign bus.sys_ready = sys_ready_q;

  rst_button_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (bus.btn_reset),
    .btn_db  (btn_db)
  );

  // Shift the asynchronous PLL lock flag into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) lock_sync <= '0;
    else       lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked};
  end

  // Next-state logic: lock loss first, then button, then counter expiry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (btn_db) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (btn_db) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register; outputs are registered from next-state so they move with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      sys_reset_q <= 1'b1;
      sys_ready_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sys_reset_q <= (state_nxt != RUN);
      sys_ready_q <= (state_nxt == RUN);
    end
  end

`ifdef RSTSEQ_LOCK_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt;

  // Count every fall back to WAIT_LOCK, sticking at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      loss_cnt <= '0;
    end else if ((state != WAIT_LOCK) && (state_nxt == WAIT_LOCK) && (loss_cnt != '1)) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

  assign bus.lock_loss_count = loss_cnt;
`else
  assign bus.lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_clk_cpu_reset_sequencer.sv
// Directed bench for clk_cpu_reset_sequencer with SYNC_STAGES=2,
// STABLE_CYCLES=8, HOLD_CYCLES=4, DEBOUNCE_CYCLES=3. Edge numbering: an
// input changed just after edge 0 is first sampled at edge 1.
module tb_clk_cpu_reset_sequencer;

  logic clock;
  logic reset;
  int   tests;
  int   failed;

  clk_cpu_reset_sequencer_if bus();

  clk_cpu_reset_sequencer #(
    .SYNC_STAGES     (2),
    .STABLE_CYCLES   (8),
    .HOLD_CYCLES     (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       btn;
    logic       exp_reset;
    logic       exp_ready;
    logic [7:0] exp_llc;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [7:0] exp_llc(input int n);
`ifdef RSTSEQ_LOCK_LOSS_COUNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Run edges first..last; sys_reset expected high for lo <= e < hi.
  task automatic win(input string nm, input int first, input int last, input int lo, input int hi);
    logic exp;
    for (int e = first; e <= last; e++) begin
      @(posedge clock);
      #1;
      exp = (e >= lo) && (e < hi);
      check($sformatf("%s.sys_reset@%0d", nm, e), {7'd0, bus.sys_reset}, {7'd0, exp});
      check($sformatf("%s.sys_ready@%0d", nm, e), {7'd0, bus.sys_ready}, {7'd0, ~exp});
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset          = 1'b1;
    bus.pll_locked = 1'b0;
    bus.btn_reset  = 1'b0;

    // Power-up table: 3 reset cycles, then lock rises; edge k = vector k+2.
    for (int i = 0; i < 20; i++) begin
      if (i < 3) begin
        vecs[i] = '{rst: 1'b1, lock: 1'b0, btn: 1'b0,
                    exp_reset: 1'b1, exp_ready: 1'b0, exp_llc: 8'd0};
      end else begin
        vecs[i] = '{rst: 1'b0, lock: 1'b1, btn: 1'b0,
                    exp_reset: ((i - 2) < 15), exp_ready: ((i - 2) >= 15), exp_llc: 8'd0};
      end
    end

    for (int i = 0; i < 20; i++) begin
      reset          = vecs[i].rst;
      bus.pll_locked = vecs[i].lock;
      bus.btn_reset  = vecs[i].btn;
      @(posedge clock);
      #1;
      check($sformatf("pwrup.sys_reset[%0d]", i), {7'd0, bus.sys_reset}, {7'd0, vecs[i].exp_reset});
      check($sformatf("pwrup.sys_ready[%0d]", i), {7'd0, bus.sys_ready}, {7'd0, vecs[i].exp_ready});
      check($sformatf("pwrup.llc[%0d]", i), bus.lock_loss_count, vecs[i].exp_llc);
    end

    // Lock loss while in RUN: reset reasserts at edge 3.
    bus.pll_locked = 1'b0;
    win("lockloss", 1, 5, 3, 1000);
    check("lockloss.llc", bus.lock_loss_count, exp_llc(1));

    // Lock glitch: 5 high, 1 low, then high; release 15 edges after final rise (edge 6).
    bus.pll_locked = 1'b1;
    win("glitch", 1, 5, 0, 1000);
    bus.pll_locked = 1'b0;
    win("glitch", 6, 6, 0, 1000);
    bus.pll_locked = 1'b1;
    win("glitch", 7, 23, 0, 21);
    check("glitch.llc", bus.lock_loss_count, exp_llc(2));

    // Short button pulse is filtered out.
    bus.btn_reset = 1'b1;
    win("btnpulse", 1, 2, 99, 99);
    bus.btn_reset = 1'b0;
    win("btnpulse", 3, 8, 99, 99);

    // 10-cycle press: reset from edge 6, released 4 edges after btn_db clears (edge 15).
    bus.btn_reset = 1'b1;
    win("btnpress", 1, 10, 6, 19);
    bus.btn_reset = 1'b0;
    win("btnpress", 11, 22, 6, 19);
    check("btnpress.llc", bus.lock_loss_count, exp_llc(2));

    // Synchronous reset in RUN: sys_reset next edge, full release 15 edges later.
    reset = 1'b1;
    win("rstrun", 1, 1, 0, 1000);
    check("rstrun.llc", bus.lock_loss_count, 8'd0);
    reset = 1'b0;
    win("rstrun", 2, 18, 0, 16);

    // Synchronous reset in HOLD restarts the whole sequence.
    bus.pll_locked = 1'b0;
    win("rsthold.drop", 1, 4, 3, 1000);
    bus.pll_locked = 1'b1;
    win("rsthold", 1, 12, 0, 1000);
    reset = 1'b1;
    win("rsthold", 13, 13, 0, 1000);
    check("rsthold.llc", bus.lock_loss_count, 8'd0);
    reset = 1'b0;
    win("rsthold", 14, 30, 0, 28);

    // Repeated lock loss: counter saturates at 255 (or stays 0 when not built).
    for (int k = 1; k <= 300; k++) begin
      bus.pll_locked = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      if (k == 1 || k == 100 || k == 255 || k == 300) begin
        check($sformatf("sat.llc@%0d", k), bus.lock_loss_count, exp_llc(k));
        check($sformatf("sat.sys_reset@%0d", k), {7'd0, bus.sys_reset}, 8'd1);
      end
      bus.pll_locked = 1'b1;
      repeat (4) @(posedge clock);
      #1;
    end
    check("sat.final", bus.lock_loss_count, exp_llc(300));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
